// File: rtl/fpu_wb_stage_if.sv
// ----------------------------------------------------------------------------
// fpu_wb_stage_if
//   Bundles the FPU-side result handshake, the register-file writeback port,
//   the flush/fflags-clear controls and the occupancy status of fpu_wb_stage.
//
//   Signal groups:
//     FPU side   : fpu_result_i, fpu_status_i, fpu_tag_i, fpu_valid_i -> stage
//                  fpu_ready_o                                       <- stage
//     Writeback  : wb_data_o, wb_tag_o, wb_valid_o                   <- stage
//                  wb_ready_i                                        -> stage
//     Control    : flush_i, fflags_clr_i                             -> stage
//     Status     : fflags_o, count_o, busy_o                         <- stage
//
//   Modports:
//     slave  - the writeback stage itself
//     master - the environment driving the stage (FPU, regfile, CSR logic)
// ----------------------------------------------------------------------------
interface fpu_wb_stage_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] fpu_result_i;
  logic [4:0]       fpu_status_i;
  logic [TAG_W-1:0] fpu_tag_i;
  logic             fpu_valid_i;
  logic             fpu_ready_o;
  logic             flush_i;
  logic [WIDTH-1:0] wb_data_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [4:0]       fflags_o;
  logic             fflags_clr_i;
  logic [CNT_W-1:0] count_o;
  logic             busy_o;

  modport slave (
    input  fpu_result_i, fpu_status_i, fpu_tag_i, fpu_valid_i,
    input  flush_i, wb_ready_i, fflags_clr_i,
    output fpu_ready_o, wb_data_o, wb_tag_o, wb_valid_o,
    output fflags_o, count_o, busy_o
  );

  modport master (
    output fpu_result_i, fpu_status_i, fpu_tag_i, fpu_valid_i,
    output flush_i, wb_ready_i, fflags_clr_i,
    input  fpu_ready_o, wb_data_o, wb_tag_o, wb_valid_o,
    input  fflags_o, count_o, busy_o
  );
endinterface

// File: rtl/fpu_wb_stage.sv
// ----------------------------------------------------------------------------
// fpu_wb_stage
//   Writeback stage behind the FPU core wrapper. Completed results
//   {result, status, tag} are accepted over a valid/ready handshake into a
//   small in-order FIFO and presented one per cycle to the register-file
//   writeback port. The IEEE status of every retired entry is ORed into a
//   sticky fflags register, which a CSR write can clear.
//
//   Ports:
//     clk_i  - clock, all state updates on the rising edge
//     rst_i  - synchronous active-high reset, overrides every other input
//     bus    - fpu_wb_stage_if.slave (FPU handshake, writeback port,
//              flush / fflags clear, fflags, occupancy count, busy)
//   Optional (macro FPU_WB_PERF_EN defined):
//     perf_retired_o - 32-bit saturating count of retired entries
//     perf_stall_o   - 32-bit saturating count of cycles with wb_valid_o=1
//                      and wb_ready_i=0
//   With FPU_WB_PERF_EN undefined neither port nor counter exists.
//
//   Timing: an accepted result is visible on the writeback port the next
//   cycle (no empty bypass). fpu_ready_o depends only on the registered
//   count, so there is no combinational path from wb_ready_i to it.
// ----------------------------------------------------------------------------
module fpu_wb_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fpu_wb_stage_if.slave     bus
`ifdef FPU_WB_PERF_EN
  ,
  output logic [31:0]       perf_retired_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Storage split per field; each entry is its own register set so it can be
  // cleared by reset, which keeps the read port free of X after a flush.
  logic [WIDTH-1:0] data_mem   [DEPTH];
  logic [4:0]       status_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [4:0]       fflags_reg;

  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic [4:0]       pop_status;

  assign not_full  = (count_reg < DEPTH_C);
  assign not_empty = (count_reg != '0);

  // A push offered during a flush is dropped even though ready is shown.
  assign push = bus.fpu_valid_i & not_full & ~bus.flush_i;
  // A pop in the flush cycle still retires and contributes its status.
  assign pop  = not_empty & bus.wb_ready_i;

  assign pop_status = status_mem[rd_ptr_reg];

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          data_mem[gi]   <= '0;
          status_mem[gi] <= '0;
          tag_mem[gi]    <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          data_mem[gi]   <= bus.fpu_result_i;
          status_mem[gi] <= bus.fpu_status_i;
          tag_mem[gi]    <= bus.fpu_tag_i;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pointers and occupancy. DEPTH is a power of two, so natural pointer
  // overflow gives the modulo-DEPTH wrap.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky exception flags. A clear drops the accumulated value but keeps
  // the status of the entry retiring in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_reg <= '0;
    end else begin
      fflags_reg <= (bus.fflags_clr_i ? 5'd0 : fflags_reg) |
                    (pop ? pop_status : 5'd0);
    end
  end

`ifdef FPU_WB_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters; untouched by flush.
  // --------------------------------------------------------------------------
  logic [31:0] perf_retired_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_retired_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (pop && (perf_retired_reg != 32'hFFFF_FFFF)) begin
        perf_retired_reg <= perf_retired_reg + 32'd1;
      end
      if (not_empty && !bus.wb_ready_i && (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_retired_o = perf_retired_reg;
  assign perf_stall_o   = perf_stall_reg;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.fpu_ready_o = not_full;
  assign bus.wb_valid_o  = not_empty;
  assign bus.wb_data_o   = data_mem[rd_ptr_reg];
  assign bus.wb_tag_o    = tag_mem[rd_ptr_reg];
  assign bus.fflags_o    = fflags_reg;
  assign bus.count_o     = count_reg;
  assign bus.busy_o      = not_empty;

endmodule

// File: tb/tb_fpu_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_fpu_wb_stage
//   Self-checking bench for fpu_wb_stage (WIDTH=32, DEPTH=4, TAG_W=5).
//   Accepted results are pushed into a scoreboard queue at the moment the
//   handshake is seen and popped/compared when the stage retires them; the
//   same monitor tracks the expected fflags. Scenario tasks add targeted
//   checks. Define FPU_WB_PERF_EN to also exercise the perf counters.
// ----------------------------------------------------------------------------
module tb_fpu_wb_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic [4:0]       status;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_wb_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

`ifdef FPU_WB_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  fpu_wb_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef FPU_WB_PERF_EN
    ,
    .perf_retired_o (perf_retired),
    .perf_stall_o   (perf_stall)
`endif
  );

  entry_t     sb_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [4:0] exp_fflags = 5'd0;

  // --------------------------------------------------------------------------
  // Scoreboard monitor, sampled on the falling edge (inputs are driven just
  // after the rising edge, so they are stable here).
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    int     sz;
    logic   do_pop;
    entry_t head;
    entry_t item;
    sz = sb_q.size();
    head = '0;

    total++;
    if (bus.wb_valid_o !== (sz != 0)) begin
      bad++;
      $display("FAIL mon_wb_valid got=%0b want=%0b t=%0t", bus.wb_valid_o, (sz != 0), $time);
    end
    total++;
    if (bus.count_o !== CNT_W'(sz)) begin
      bad++;
      $display("FAIL mon_count got=%0d want=%0d t=%0t", bus.count_o, sz, $time);
    end
    total++;
    if (bus.fpu_ready_o !== (sz < DEPTH)) begin
      bad++;
      $display("FAIL mon_fpu_ready got=%0b want=%0b t=%0t", bus.fpu_ready_o, (sz < DEPTH), $time);
    end
    total++;
    if (bus.fflags_o !== exp_fflags) begin
      bad++;
      $display("FAIL mon_fflags got=%0h want=%0h t=%0t", bus.fflags_o, exp_fflags, $time);
    end

    do_pop = (sz != 0) && (bus.wb_ready_i === 1'b1);
    if (do_pop) begin
      head = sb_q.pop_front();
      total++;
      if ((bus.wb_data_o !== head.data) || (bus.wb_tag_o !== head.tag)) begin
        bad++;
        $display("FAIL mon_retire got=%h/%0d want=%h/%0d t=%0t",
                 bus.wb_data_o, bus.wb_tag_o, head.data, head.tag, $time);
      end
    end

    if (rst) begin
      sb_q.delete();
      exp_fflags = 5'd0;
    end else begin
      exp_fflags = (bus.fflags_clr_i ? 5'd0 : exp_fflags) | (do_pop ? head.status : 5'd0);
      if (bus.flush_i) begin
        sb_q.delete();
      end else if (bus.fpu_valid_i && (sz < DEPTH)) begin
        item.data   = bus.fpu_result_i;
        item.tag    = bus.fpu_tag_i;
        item.status = bus.fpu_status_i;
        sb_q.push_back(item);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t, input logic [4:0] s);
    bus.fpu_result_i = d;
    bus.fpu_tag_i    = t;
    bus.fpu_status_i = s;
    bus.fpu_valid_i  = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    // Reset must override a push, pop, flush and clear offered alongside it.
    rst = 1'b1;
    offer(32'hAAAA_5555, 5'd3, 5'h1F);
    bus.wb_ready_i   = 1'b1;
    bus.flush_i      = 1'b1;
    bus.fflags_clr_i = 1'b1;
    step();
    step();
    total++;
    if (bus.fpu_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.fpu_ready_o); end
    total++;
    if (bus.wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b want=0", bus.wb_valid_o); end
    total++;
    if (bus.wb_data_o !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h want=0", bus.wb_data_o); end
    total++;
    if (bus.wb_tag_o !== 5'd0) begin bad++; $display("FAIL reset_wb_tag got=%0d want=0", bus.wb_tag_o); end
    total++;
    if (bus.fflags_o !== 5'd0) begin bad++; $display("FAIL reset_fflags got=%0h want=0", bus.fflags_o); end
    total++;
    if (bus.count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count_o); end
    total++;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy_o); end
    rst              = 1'b0;
    bus.fpu_valid_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.fflags_clr_i = 1'b0;
    bus.wb_ready_i   = 1'b0;
    $display("reset: state checked");
  endtask

`ifdef FPU_WB_PERF_EN
  task automatic test_perf();
    bus.wb_ready_i = 1'b0;
    offer(32'hCAFE_0001, 5'd1, 5'd0);
    step();
    bus.fpu_valid_i = 1'b0;
    repeat (7) step();
    total++;
    if (perf_stall !== 32'd7) begin bad++; $display("FAIL perf_stall_hold got=%0d want=7", perf_stall); end
    total++;
    if (perf_retired !== 32'd0) begin bad++; $display("FAIL perf_retired_hold got=%0d want=0", perf_retired); end
    bus.wb_ready_i = 1'b1;
    step();
    total++;
    if (perf_stall !== 32'd7) begin bad++; $display("FAIL perf_stall got=%0d want=7", perf_stall); end
    total++;
    if (perf_retired !== 32'd1) begin bad++; $display("FAIL perf_retired got=%0d want=1", perf_retired); end
    $display("perf: stall=%0d retired=%0d", perf_stall, perf_retired);
  endtask
`endif

  task automatic test_single();
    bus.wb_ready_i = 1'b1;
    offer(32'h3F80_0000, 5'd5, 5'd0);
    step();
    bus.fpu_valid_i = 1'b0;
    total++;
    if (bus.wb_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", bus.wb_valid_o); end
    total++;
    if (bus.wb_data_o !== 32'h3F80_0000) begin bad++; $display("FAIL single_data got=%h want=3f800000", bus.wb_data_o); end
    total++;
    if (bus.wb_tag_o !== 5'd5) begin bad++; $display("FAIL single_tag got=%0d want=5", bus.wb_tag_o); end
    step();
    total++;
    if (bus.count_o !== 3'd0) begin bad++; $display("FAIL single_count got=%0d want=0", bus.count_o); end
    $display("single: data=3f800000 tag=5 retired");
  endtask

  task automatic test_fill();
    bus.wb_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      offer($urandom, TAG_W'(i), 5'd0);
      step();
    end
    bus.fpu_valid_i = 1'b0;
    total++;
    if (bus.count_o !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", bus.count_o); end
    total++;
    if (bus.fpu_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b want=0", bus.fpu_ready_o); end
    offer(32'h0BAD_0BAD, 5'd9, 5'd0);
    step();
    bus.fpu_valid_i = 1'b0;
    total++;
    if (bus.count_o !== 3'd4) begin bad++; $display("FAIL fill_fifth_count got=%0d want=4", bus.count_o); end
    bus.wb_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (bus.wb_tag_o !== TAG_W'(i)) begin bad++; $display("FAIL fill_order got=%0d want=%0d", bus.wb_tag_o, i); end
      step();
      if (i == 1) begin
        total++;
        if (bus.fpu_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready_rise got=%0b want=1", bus.fpu_ready_o); end
      end
    end
    total++;
    if (bus.count_o !== 3'd0) begin bad++; $display("FAIL fill_drain got=%0d want=0", bus.count_o); end
    $display("fill: tags 1..4 drained");
  endtask

  task automatic test_back_to_back();
    int n;
    bus.wb_ready_i = 1'b0;
    offer($urandom, 5'd10, 5'd0);
    step();
    offer($urandom, 5'd11, 5'd0);
    step();
    bus.wb_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer($urandom, TAG_W'(12 + i), 5'd0);
      step();
      total++;
      if (bus.count_o !== 3'd2) begin bad++; $display("FAIL b2b_count cycle=%0d got=%0d want=2", i, bus.count_o); end
    end
    bus.fpu_valid_i = 1'b0;
    n = 0;
    while ((bus.count_o !== 3'd0) && (n < 10)) begin
      step();
      n++;
    end
    total++;
    if (bus.count_o !== 3'd0) begin bad++; $display("FAIL b2b_drain got=%0d want=0", bus.count_o); end
    $display("back_to_back: 12 entries streamed at count=2");
  endtask

  task automatic test_fflags();
    bus.wb_ready_i   = 1'b0;
    bus.fflags_clr_i = 1'b1;
    step();
    bus.fflags_clr_i = 1'b0;
    offer(32'h1, 5'd1, 5'h01);
    step();
    offer(32'h2, 5'd2, 5'h10);
    step();
    offer(32'h3, 5'd3, 5'h04);
    step();
    bus.fpu_valid_i = 1'b0;
    bus.wb_ready_i  = 1'b1;
    step();
    step();
    total++;
    if (bus.fflags_o !== 5'h11) begin bad++; $display("FAIL fflags_accum got=%0h want=11", bus.fflags_o); end
    bus.fflags_clr_i = 1'b1;
    step();
    bus.fflags_clr_i = 1'b0;
    total++;
    if (bus.fflags_o !== 5'h04) begin bad++; $display("FAIL fflags_clr_pop got=%0h want=4", bus.fflags_o); end
    $display("fflags: accum=11 then clear+retire=04");
  endtask

  task automatic test_flush();
    bus.wb_ready_i = 1'b0;
    offer(32'h2000_0000, 5'd20, 5'd0);
    step();
    offer(32'h2100_0000, 5'd21, 5'd0);
    step();
    offer(32'h2200_0000, 5'd22, 5'd0);
    step();
    offer(32'hDEAD_BEEF, 5'd23, 5'd0);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i     = 1'b0;
    bus.fpu_valid_i = 1'b0;
    total++;
    if (bus.count_o !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", bus.count_o); end
    total++;
    if (bus.wb_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", bus.wb_valid_o); end
    total++;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b want=0", bus.busy_o); end
    bus.wb_ready_i = 1'b1;
    offer(32'h1234_5678, 5'd24, 5'd0);
    step();
    bus.fpu_valid_i = 1'b0;
    total++;
    if (bus.wb_data_o !== 32'h1234_5678) begin bad++; $display("FAIL flush_next_data got=%h want=12345678", bus.wb_data_o); end
    total++;
    if (bus.wb_tag_o !== 5'd24) begin bad++; $display("FAIL flush_next_tag got=%0d want=24", bus.wb_tag_o); end
    step();
    total++;
    if (bus.count_o !== 3'd0) begin bad++; $display("FAIL flush_final_count got=%0d want=0", bus.count_o); end
    $display("flush: 3 entries discarded, offered push dropped");
  endtask

  initial begin
    bus.fpu_result_i = '0;
    bus.fpu_status_i = '0;
    bus.fpu_tag_i    = '0;
    bus.fpu_valid_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.wb_ready_i   = 1'b0;
    bus.fflags_clr_i = 1'b0;
    test_reset();
`ifdef FPU_WB_PERF_EN
    test_perf();
`endif
    test_single();
    test_fill();
    test_back_to_back();
    test_fflags();
    test_flush();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_wb_stage.md
Name: fpu_wb_stage

Overview:
Writeback stage directly downstream of the FPU core wrapper. It accepts completed results (result, status, tag) over a valid/ready handshake into a small in-order FIFO. It presents them one per cycle to the register-file writeback port and accumulates the sticky IEEE exception flags (fflags) of retired results. It decouples FPU back-pressure from register-file port arbitration.

Parameters:
- WIDTH, 32, result datapath width in bits; 32 or 64.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_W, 5, tag width; matches the FPU tag width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- fpu_result_i  in  WIDTH  FPU result.
- fpu_status_i  in  5  FPU status flags {NV,DZ,OF,UF,NX}.
- fpu_tag_i  in  TAG_W  FPU tag.
- fpu_valid_i  in  1  FPU output valid.
- fpu_ready_o  out  1  ready to the FPU output.
- flush_i  in  1  discards all buffered entries.
- wb_data_o  out  WIDTH  writeback data.
- wb_tag_o  out  TAG_W  writeback tag (destination identifier).
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  register-file port accepts.
- fflags_o  out  5  sticky OR of the status of retired entries.
- fflags_clr_i  in  1  clears fflags (CSR write).
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- busy_o  out  1  asserted when count_o is non-zero.

Behaviour:
- Reset (rst_i=1 at the edge):
  - wr_ptr, rd_ptr, count and fflags all go to 0.
  - Storage clears to 0.
  - Outputs after reset: fpu_ready_o=1, wb_valid_o=0, wb_data_o=0, wb_tag_o=0, fflags_o=0, count_o=0, busy_o=0.
  - rst_i overrides every other input, including a push, pop or flush in the same cycle.
- Push: occurs when fpu_valid_i & fpu_ready_o. Writes {result, status, tag} at wr_ptr, then wr_ptr increments (wrapping mod DEPTH).
- fpu_ready_o = (count < DEPTH). There is no combinational path from wb_ready_i to fpu_ready_o. When full, no push occurs even if a pop happens in the same cycle.
- Pop: occurs when wb_valid_o & wb_ready_i. rd_ptr increments (wrapping mod DEPTH).
- wb_valid_o = (count != 0). wb_data_o and wb_tag_o read storage at rd_ptr combinationally, and are stable while wb_valid_o=1 and wb_ready_i=0.
- Latency: a result accepted in cycle N is visible on wb_valid_o in cycle N+1. There is no empty-bypass.
- Count update:
  - push only: count +1.
  - pop only: count -1.
  - push and pop together (possible when not full and not empty): count unchanged.
- Ordering: strictly FIFO. Tags are passed through and never reordered or interpreted.
- fflags next-state:
  - fflags_clr_i=0: fflags | (pop ? popped_status : 0).
  - fflags_clr_i=1: (pop ? popped_status : 0). Clear wins over the old value, but the status of an entry retiring in the same cycle is kept.
- Flush (flush_i=1):
  - Next cycle: count=0, wr_ptr=rd_ptr=0, wb_valid_o=0.
  - A push offered in the flush cycle is dropped; fpu_ready_o still shows its normal value that cycle.
  - A pop handshake in the flush cycle still retires, and its status is ORed into fflags.
  - fflags is otherwise unaffected by flush.
- Storage contents are don't-care after a flush, but wb_data_o/wb_tag_o must not be X.

Optional Feature:
- Macro: FPU_WB_PERF_EN.
- When defined, adds two ports, both 32-bit, reset to 0, saturating at 0xFFFF_FFFF, and not cleared by flush:
  - perf_retired_o (out, 32): increments on each pop.
  - perf_stall_o (out, 32): increments each cycle with wb_valid_o & !wb_ready_i.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset, then push result 0x3F80_0000, tag 5, status 0 with wb_ready_i=1 -> wb_valid_o=1 one cycle later with wb_data_o=0x3F80_0000 and wb_tag_o=5; count_o returns to 0 after the pop.
- wb_ready_i=0, push tags 1,2,3,4 (DEPTH=4) -> count_o=4 and fpu_ready_o=0; a fifth offered result is not accepted; releasing wb_ready_i drains tags 1,2,3,4 in order, and fpu_ready_o rises the cycle after the first pop.
- Simultaneous push and pop at count=2 for 10 cycles -> count_o stays 2 and the data order is preserved; pointers wrap past DEPTH without loss.
- Retire entries with status 0x01 then 0x10 -> fflags_o=0x11; assert fflags_clr_i in the same cycle as retiring status 0x04 -> fflags_o=0x04 next cycle.
- Three entries buffered, assert flush_i with a concurrent push offer -> next cycle count_o=0, wb_valid_o=0, busy_o=0; the offered result never appears on wb_data_o.
- With FPU_WB_PERF_EN: hold wb_ready_i=0 for 7 cycles with one entry buffered, then pop -> perf_stall_o=7 and perf_retired_o=1.
